// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, entry type and counter sizing for the buffered fetch unit
package fetch_pkg;
    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; push while full is accepted only alongside a pop
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic [WIDTH-1:0]                     push_data,
    input  logic                                 pop,
    input  logic                                 flush,
    output logic [WIDTH-1:0]                     pop_data,
    output logic [fetch_pkg::cnt_w(DEPTH)-1:0]   count,
    output logic                                 full,
    output logic                                 empty
);
    import fetch_pkg::*;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/fetch_unit_buffered.sv
// fetch_unit_buffered: credit-limited in-order instruction fetch with redirect flush
// and a buffered, backpressured output toward decode.
module fetch_unit_buffered #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4,
    parameter int              DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          imem_req_valid,
    output logic [XLEN-1:0]               imem_req_addr,
    input  logic                          imem_req_ready,
    input  logic                          imem_rsp_valid,
    input  logic [fetch_pkg::INSTR_W-1:0] imem_rsp_data,
    output logic                          out_valid,
    output logic [XLEN-1:0]               out_pc,
    output logic [fetch_pkg::INSTR_W-1:0] out_instr,
    input  logic                          out_ready
);
    import fetch_pkg::*;
    localparam int CW = cnt_w(DEPTH);
    localparam int SW = CW + 2;
    logic [XLEN-1:0]         fetch_pc, pcq_head;
    logic [CW-1:0]           inflight, drop_cnt, out_count;
    logic [XLEN+INSTR_W-1:0] out_head;
    logic                    credit, accept, rsp_keep, out_pop;
    logic                    pcq_full, pcq_empty, out_full, out_empty;
    // Every slot is either awaiting imem (kept or to be dropped) or sitting in the out FIFO.
    assign credit         = (SW'(inflight) + SW'(drop_cnt) + SW'(out_count)) < SW'(DEPTH);
    assign imem_req_valid = reset && credit && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && !redirect_valid && drop_cnt == '0;
    assign out_valid      = !out_empty;
    assign out_pop        = out_valid && out_ready;
    assign {out_pc, out_instr} = out_head;
    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
        .clk, .reset,
        .push(accept), .push_data(fetch_pc), .pop(rsp_keep), .flush(redirect_valid),
        .pop_data(pcq_head), .count(inflight), .full(pcq_full), .empty(pcq_empty)
    );
    fetch_fifo #(.WIDTH(XLEN + INSTR_W), .DEPTH(DEPTH)) u_out_q (
        .clk, .reset,
        .push(rsp_keep), .push_data({pcq_head, imem_rsp_data}), .pop(out_pop), .flush(redirect_valid),
        .pop_data(out_head), .count(out_count), .full(out_full), .empty(out_empty)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            fetch_pc <= redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00}
                      : accept         ? fetch_pc + XLEN'(PC_STEP)
                      : fetch_pc;
            drop_cnt <= redirect_valid                      ? drop_cnt + inflight - CW'(imem_rsp_valid)
                      : (imem_rsp_valid && drop_cnt != '0) ? drop_cnt - CW'(1)
                      : drop_cnt;
        end
    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (inflight != '0 || drop_cnt != '0));
    a_keep_room: assert property (@(posedge clk) disable iff (!reset)
        rsp_keep |-> (!pcq_empty && !out_full));
    a_accept_room: assert property (@(posedge clk) disable iff (!reset)
        accept |-> !pcq_full);
endmodule

// File: tb/tb_fetch_unit_buffered.sv
// tb_fetch_unit_buffered: directed table, corner sequences and randomized run against a queue model
module tb_fetch_unit_buffered;
    import fetch_pkg::*;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid, out_valid, out_ready;
    logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, out_pc, out_instr;
    fetch_unit_buffered #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit          rv;
        logic [31:0] rpc;
        bit          rdy;
        bit          rsp_v;
        logic [31:0] rsp_pc;
        bit          ordy;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_ov;
        logic [31:0] e_opc;
    } vec_t;
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;
    int           vectors = 0;
    int           errors = 0;
    int           cyc = 0;
    int           epoch = 0;
    int           dut_acc = 0;
    logic [31:0]  mpc = 32'h0;
    logic [31:0]  last_addr = 32'h0;
    req_t         imem_q[$];
    fetch_entry_t outq[$];
    vec_t         tbl[11];
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask
    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        imem_q.delete();
        outq.delete();
        mpc = 32'h0;
        epoch++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask
    // One clock of model-checked operation; the model is the program-order PC stream plus
    // an in-order imem queue tagged by redirect epoch.
    task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy, input bit ordy, input bit rsp_en);
        bit   rsp, exp_v;
        req_t e;
        rsp = rsp_en && imem_q.size() > 0 && imem_q[0].due <= cyc;
        exp_v = !rv && (imem_q.size() + outq.size() < DEPTH);
        redirect_valid = rv;
        redirect_pc = rpc;
        imem_req_ready = rdy;
        out_ready = ordy;
        imem_rsp_valid = rsp;
        imem_rsp_data = rsp ? instr_of(imem_q[0].addr) : $urandom;
        @(negedge clk);
        last_addr = imem_req_addr;
        if (imem_req_valid && rdy) dut_acc++;
        chk("req_valid", imem_req_valid, exp_v);
        if (exp_v) chk("req_addr", imem_req_addr, mpc);
        chk("out_valid", out_valid, outq.size() > 0);
        if (outq.size() > 0) begin
            chk("out_pc", out_pc, outq[0].pc);
            chk("out_instr", out_instr, outq[0].instr);
        end
        @(posedge clk);
        if (ordy && outq.size() > 0) outq.delete(0);
        if (rsp) begin
            e = imem_q.pop_front();
            if (!rv && e.epoch == epoch) outq.push_back('{pc: e.addr, instr: instr_of(e.addr)});
        end
        if (rv) begin
            outq.delete();
            epoch++;
            mpc = {rpc[31:2], 2'b00};
        end else if (exp_v && rdy) begin
            imem_q.push_back('{addr: mpc, epoch: epoch, due: cyc + 1});
            mpc += 32'd4;
        end
        cyc++;
        #1;
    endtask
    initial begin
        // rv, rpc, rdy, rsp_v, rsp_pc, ordy | req_valid, req_addr, out_valid, out_pc
        tbl[0]  = '{0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h0,   0, 32'h0};
        tbl[1]  = '{0, 32'h0,   1, 1, 32'h0,   1, 1, 32'h4,   0, 32'h0};
        tbl[2]  = '{0, 32'h0,   1, 1, 32'h4,   1, 1, 32'h8,   1, 32'h0};
        tbl[3]  = '{0, 32'h0,   1, 1, 32'h8,   1, 1, 32'hC,   1, 32'h4};
        tbl[4]  = '{0, 32'h0,   1, 0, 32'h0,   1, 1, 32'h10,  1, 32'h8};
        tbl[5]  = '{1, 32'h103, 1, 0, 32'h0,   1, 0, 32'h14,  0, 32'h0};
        tbl[6]  = '{0, 32'h0,   1, 1, 32'hC,   1, 1, 32'h100, 0, 32'h0};
        tbl[7]  = '{0, 32'h0,   1, 1, 32'h10,  1, 1, 32'h104, 0, 32'h0};
        tbl[8]  = '{0, 32'h0,   1, 1, 32'h100, 1, 1, 32'h108, 0, 32'h0};
        tbl[9]  = '{0, 32'h0,   1, 1, 32'h104, 1, 1, 32'h10C, 1, 32'h100};
        tbl[10] = '{0, 32'h0,   0, 0, 32'h0,   1, 1, 32'h110, 1, 32'h104};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            redirect_valid = tbl[i].rv;
            redirect_pc = tbl[i].rpc;
            imem_req_ready = tbl[i].rdy;
            imem_rsp_valid = tbl[i].rsp_v;
            imem_rsp_data = tbl[i].rsp_v ? instr_of(tbl[i].rsp_pc) : 32'h0;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk("tbl_req_valid", imem_req_valid, tbl[i].e_rv);
            chk("tbl_req_addr", imem_req_addr, tbl[i].e_addr);
            chk("tbl_out_valid", out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk("tbl_out_pc", out_pc, tbl[i].e_opc);
                chk("tbl_out_instr", out_instr, instr_of(tbl[i].e_opc));
            end
            @(posedge clk);
            #1;
        end
        // Decode stalled: credit caps acceptance at DEPTH requests.
        do_reset();
        dut_acc = 0;
        repeat (8) cycle(0, 32'h0, 1, 0, 1);
        chk("t3_accepts", dut_acc, 4);
        cycle(0, 32'h0, 0, 1, 1);
        // imem stalled: request address must hold.
        repeat (3) begin
            cycle(0, 32'h0, 0, 0, 1);
            chk("t5_addr_hold", last_addr, 32'h10);
        end
        cycle(0, 32'h0, 1, 0, 1);
        repeat (6) cycle(0, 32'h0, 0, 1, 1);
        // Address wrap at the top of the space.
        cycle(1, 32'hFFFF_FFFE, 0, 1, 1);
        cycle(0, 32'h0, 1, 1, 1);
        chk("t6_top_addr", last_addr, 32'hFFFF_FFFC);
        cycle(0, 32'h0, 1, 1, 1);
        chk("t6_wrap", last_addr, 32'h0);
        repeat (4) cycle(0, 32'h0, 1, 1, 1);
        chk("t6_pre_reset_valid", out_valid, 1);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 99) < 3, $urandom, $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
